// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/response bundle for mem_access_ctrl.
// The master modport is the datapath/control unit; the slave modport is the sequencer.
interface mem_access_ctrl_if;
    logic        Req;
    logic        WrEn;
    logic [19:0] Addr;
    logic [15:0] WrData;
    logic [15:0] RdData;
    logic        Ready;
    logic        Busy;

    modport master (
        output Req, WrEn, Addr, WrData,
        input  RdData, Ready, Busy
    );

    modport slave (
        input  Req, WrEn, Addr, WrData,
        output RdData, Ready, Busy
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// LC-3 SRAM access sequencer: IDLE -> SETUP -> ACCESS (WAIT_STATES cycles) -> DONE.
// Optional macro MEM_IO_MAP_EN: IO_ADDR reads Switches and writes HexData instead of the SRAM.
module mem_access_ctrl #(
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [19:0] IO_ADDR     = 20'h0FFFF
) (
    input  logic             Clk,
    input  logic             Reset,
    mem_access_ctrl_if.slave bus,
    output logic             Sram_CE,
    output logic             Sram_UB,
    output logic             Sram_LB,
    output logic             Sram_OE,
    output logic             Sram_WE,
    output logic [19:0]      Sram_ADDR,
    output logic [15:0]      Sram_DQ_Out,
    output logic             Sram_DQ_En,
    input  logic [15:0]      Sram_DQ_In,
    input  logic [15:0]      Switches,
    output logic [15:0]      HexData
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        wr_q;
    logic        io_q;
    logic        io_hit;
    logic        ce_n;
    logic        oe_n;
    logic        we_n;
    logic        dq_en;
    logic [19:0] sram_addr;
    logic [15:0] dq_out;
    logic [15:0] rd_data;
    logic [15:0] rd_src;
    logic        ready;
    logic        busy;

`ifdef MEM_IO_MAP_EN
    logic [15:0] hex_q;

    assign io_hit = (bus.Addr == IO_ADDR);
    assign rd_src = io_q ? Switches : Sram_DQ_In;

    // The I/O write lands when DONE retires, mirroring the SRAM write hold point.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hex_q <= '0;
        end else if (state == DONE && wr_q && io_q) begin
            hex_q <= dq_out;
        end
    end

    assign HexData = hex_q;
`else
    logic unused_io;

    assign io_hit    = 1'b0;
    assign rd_src    = Sram_DQ_In;
    assign HexData   = '0;
    assign unused_io = (^Switches) ^ (^IO_ADDR);
`endif

    // Strobes are registered on the edge entering each state, so they are
    // valid for the whole of the state they belong to.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            wr_q      <= 1'b0;
            io_q      <= 1'b0;
            ce_n      <= 1'b1;
            oe_n      <= 1'b1;
            we_n      <= 1'b1;
            dq_en     <= 1'b0;
            sram_addr <= '0;
            dq_out    <= '0;
            rd_data   <= '0;
            ready     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Req) begin
                        wr_q   <= bus.WrEn;
                        io_q   <= io_hit;
                        dq_out <= bus.WrData;
                        busy   <= 1'b1;
                        state  <= SETUP;
                        if (!io_hit) begin
                            sram_addr <= bus.Addr;
                            ce_n      <= 1'b0;
                            oe_n      <= bus.WrEn;
                            dq_en     <= bus.WrEn;
                        end
                    end
                end
                SETUP: begin
                    wait_cnt <= 4'(WAIT_STATES - 1);
                    we_n     <= ~wr_q | io_q;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (wait_cnt == '0) begin
                        oe_n  <= 1'b1;
                        we_n  <= 1'b1;
                        ready <= 1'b1;
                        state <= DONE;
                        if (!wr_q) begin
                            rd_data <= rd_src;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                DONE: begin
                    ce_n  <= 1'b1;
                    dq_en <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign Sram_CE     = ce_n;
    assign Sram_UB     = ce_n;
    assign Sram_LB     = ce_n;
    assign Sram_OE     = oe_n;
    assign Sram_WE     = we_n;
    assign Sram_ADDR   = sram_addr;
    assign Sram_DQ_Out = dq_out;
    assign Sram_DQ_En  = dq_en;
    assign bus.RdData  = rd_data;
    assign bus.Ready   = ready;
    assign bus.Busy    = busy;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed protocol steps plus random
// reads/writes scored against a behavioural SRAM and per-access strobe counts.
module tb_mem_access_ctrl;

    localparam int unsigned W = 2;
`ifdef MEM_IO_MAP_EN
    localparam bit IO_MAP = 1'b1;
`else
    localparam bit IO_MAP = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    mem_access_ctrl_if b0 ();
    mem_access_ctrl_if b1 ();
    mem_access_ctrl_if b15 ();

    logic        ce, ub, lb, oe, we, dq_en;
    logic [19:0] sram_addr;
    logic [15:0] dq_out, dq_in, switches, hex_data;

    logic        x1_ce, x1_ub, x1_lb, x1_oe, x1_we, x1_en;
    logic [19:0] x1_addr;
    logic [15:0] x1_out, x1_hex;
    logic        x15_ce, x15_ub, x15_lb, x15_oe, x15_we, x15_en;
    logic [19:0] x15_addr;
    logic [15:0] x15_out, x15_hex;

    mem_access_ctrl #(.WAIT_STATES(W), .IO_ADDR(20'h0FFFF)) u_dut (
        .Clk(Clk), .Reset(Reset), .bus(b0.slave),
        .Sram_CE(ce), .Sram_UB(ub), .Sram_LB(lb), .Sram_OE(oe), .Sram_WE(we),
        .Sram_ADDR(sram_addr), .Sram_DQ_Out(dq_out), .Sram_DQ_En(dq_en),
        .Sram_DQ_In(dq_in), .Switches(switches), .HexData(hex_data)
    );

    mem_access_ctrl #(.WAIT_STATES(1), .IO_ADDR(20'h0FFFF)) u_w1 (
        .Clk(Clk), .Reset(Reset), .bus(b1.slave),
        .Sram_CE(x1_ce), .Sram_UB(x1_ub), .Sram_LB(x1_lb), .Sram_OE(x1_oe), .Sram_WE(x1_we),
        .Sram_ADDR(x1_addr), .Sram_DQ_Out(x1_out), .Sram_DQ_En(x1_en),
        .Sram_DQ_In(16'h5A5A), .Switches(16'h0000), .HexData(x1_hex)
    );

    mem_access_ctrl #(.WAIT_STATES(15), .IO_ADDR(20'h0FFFF)) u_w15 (
        .Clk(Clk), .Reset(Reset), .bus(b15.slave),
        .Sram_CE(x15_ce), .Sram_UB(x15_ub), .Sram_LB(x15_lb), .Sram_OE(x15_oe), .Sram_WE(x15_we),
        .Sram_ADDR(x15_addr), .Sram_DQ_Out(x15_out), .Sram_DQ_En(x15_en),
        .Sram_DQ_In(16'hA5A5), .Switches(16'h0000), .HexData(x15_hex)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;

    function automatic logic [15:0] init_word(input int unsigned i);
        return 16'(i * 40503 + 4660);
    endfunction

    // Behavioural asynchronous SRAM (64 words aliased on the low address bits).
    logic [15:0] sram_model [64];
    logic        dq_ovr_en;
    logic [15:0] dq_ovr;
    assign dq_in = dq_ovr_en ? dq_ovr : sram_model[sram_addr[5:0]];

    always @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 64; i++) sram_model[i] <= init_word(i);
        end else if (!ce && !we && dq_en) begin
            sram_model[sram_addr[5:0]] <= dq_out;
        end
    end

    // Cumulative per-cycle protocol counters, sampled mid-cycle.
    logic [15:0] exp_wdata;
    logic [19:0] exp_addr;
    int unsigned m_oe = 0, m_we = 0, m_en = 0, m_ce = 0, m_busy = 0, m_ready = 0;
    int unsigned m_overlap = 0, m_dqbad = 0, m_addrbad = 0, m_ubbad = 0;

    always @(negedge Clk) begin
        if (!oe) m_oe <= m_oe + 1;
        if (!we) m_we <= m_we + 1;
        if (dq_en) m_en <= m_en + 1;
        if (!ce) m_ce <= m_ce + 1;
        if (b0.Busy) m_busy <= m_busy + 1;
        if (b0.Ready) m_ready <= m_ready + 1;
        if (dq_en && !oe) m_overlap <= m_overlap + 1;
        if (dq_en && dq_out !== exp_wdata) m_dqbad <= m_dqbad + 1;
        if (!ce && sram_addr !== exp_addr) m_addrbad <= m_addrbad + 1;
        if (ub !== ce || lb !== ce) m_ubbad <= m_ubbad + 1;
    end

    logic [15:0] ref_mem [64];
    logic [15:0] exp_hex;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic reinit_ref();
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        exp_hex = 16'h0000;
    endtask

    task automatic do_access(input logic wr, input logic [19:0] a, input logic [15:0] d, input string tag);
        int unsigned s_oe, s_we, s_en, s_ce, s_busy, s_ready, s_ov, s_dq, s_ad, s_ub;
        int unsigned lat;
        logic        seen, io;
        logic [15:0] rd_before, exp_rd;
        s_oe = m_oe; s_we = m_we; s_en = m_en; s_ce = m_ce; s_busy = m_busy;
        s_ready = m_ready; s_ov = m_overlap; s_dq = m_dqbad; s_ad = m_addrbad; s_ub = m_ubbad;
        io = IO_MAP && (a == 20'h0FFFF);
        rd_before = b0.RdData;
        exp_wdata = d;
        exp_addr = a;
        b0.Req = 1'b1; b0.WrEn = wr; b0.Addr = a; b0.WrData = d;
        @(posedge Clk);
        #1 b0.Req = 1'b0;
        lat = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge Clk);
            lat++;
            if (b0.Ready) seen = 1'b1;
        end
        check({tag, "_latency"}, lat, W + 2);
        @(posedge Clk);
        #1;
        if (!wr) exp_rd = io ? switches : (dq_ovr_en ? dq_ovr : ref_mem[a[5:0]]);
        else exp_rd = rd_before;
        if (wr && io) exp_hex = d;
        if (wr && !io) ref_mem[a[5:0]] = d;
        check({tag, "_rddata"}, 32'(b0.RdData), 32'(exp_rd));
        check({tag, "_hexdata"}, 32'(hex_data), 32'(exp_hex));
        check({tag, "_oe_cycles"}, m_oe - s_oe, (!wr && !io) ? W + 1 : 0);
        check({tag, "_we_cycles"}, m_we - s_we, (wr && !io) ? W : 0);
        check({tag, "_dqen_cycles"}, m_en - s_en, (wr && !io) ? W + 2 : 0);
        check({tag, "_ce_cycles"}, m_ce - s_ce, io ? 0 : W + 2);
        check({tag, "_busy_cycles"}, m_busy - s_busy, W + 2);
        check({tag, "_ready_pulses"}, m_ready - s_ready, 1);
        check({tag, "_en_oe_overlap"}, m_overlap - s_ov, 0);
        check({tag, "_dq_value"}, m_dqbad - s_dq, 0);
        check({tag, "_addr_value"}, m_addrbad - s_ad, 0);
        check({tag, "_ub_lb"}, m_ubbad - s_ub, 0);
        check({tag, "_idle_strobes"}, {28'd0, ce, oe, we, dq_en}, {28'd0, 4'b1110});
        check({tag, "_idle_busy"}, 32'(b0.Busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned lat, starts, readies, cyc, st1, st2;
        logic        prev_busy, seen;

        Reset = 1'b1;
        b0.Req = 1'b0; b0.WrEn = 1'b0; b0.Addr = '0; b0.WrData = '0;
        b1.Req = 1'b0; b1.WrEn = 1'b0; b1.Addr = '0; b1.WrData = '0;
        b15.Req = 1'b0; b15.WrEn = 1'b0; b15.Addr = '0; b15.WrData = '0;
        switches = 16'h0000;
        dq_ovr_en = 1'b0; dq_ovr = '0;
        exp_wdata = '0; exp_addr = '0;
        reinit_ref();
        repeat (3) @(posedge Clk);
        #1;
        check("reset_strobes", {27'd0, ce, ub, lb, oe, we}, {27'd0, 5'b11111});
        check("reset_dq_en", 32'(dq_en), 0);
        check("reset_addr", 32'(sram_addr), 0);
        check("reset_rddata", 32'(b0.RdData), 0);
        check("reset_ready_busy", {30'd0, b0.Ready, b0.Busy}, 0);
        check("reset_hexdata", 32'(hex_data), 0);
        Reset = 1'b0;
        @(posedge Clk);
        #1;

        dq_ovr_en = 1'b1; dq_ovr = 16'h1234;
        do_access(1'b0, 20'h00010, 16'h0000, "read_1234");
        check("read_1234_value", 32'(b0.RdData), 32'h1234);
        dq_ovr_en = 1'b0;

        do_access(1'b1, 20'h00020, 16'hBEEF, "write_beef");
        check("write_beef_stored", 32'(sram_model[6'h20]), 32'hBEEF);
        do_access(1'b0, 20'h00020, 16'h0000, "readback_beef");

        // Abort a write in its first ACCESS cycle.
        exp_wdata = 16'hCAFE; exp_addr = 20'h00005;
        b0.Req = 1'b1; b0.WrEn = 1'b1; b0.Addr = 20'h00005; b0.WrData = 16'hCAFE;
        @(posedge Clk);
        #1 b0.Req = 1'b0;
        @(posedge Clk);
        #1;
        check("abort_pre_we_low", 32'(we), 0);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        check("abort_we", 32'(we), 1);
        check("abort_dq_en", 32'(dq_en), 0);
        check("abort_ce", 32'(ce), 1);
        check("abort_busy", 32'(b0.Busy), 0);
        check("abort_ready", 32'(b0.Ready), 0);
        check("abort_rddata", 32'(b0.RdData), 0);
        Reset = 1'b0;
        reinit_ref();
        do_access(1'b0, 20'h00007, 16'h0000, "post_abort_read");

        // Req held high for two back-to-back reads.
        exp_addr = 20'h00011;
        b0.Req = 1'b1; b0.WrEn = 1'b0; b0.Addr = 20'h00011;
        starts = 0; readies = 0; cyc = 0; st1 = 0; st2 = 0; prev_busy = 1'b0;
        for (int i = 0; i < 40 && readies < 2; i++) begin
            @(negedge Clk);
            cyc++;
            if (b0.Busy && !prev_busy) begin
                starts++;
                if (starts == 1) st1 = cyc;
                else begin
                    st2 = cyc;
                    b0.Req = 1'b0;
                end
            end
            if (b0.Ready) readies++;
            prev_busy = b0.Busy;
        end
        b0.Req = 1'b0;
        check("b2b_setup_spacing", st2 - st1, W + 3);
        check("b2b_ready_count", readies, 2);
        check("b2b_rddata", 32'(b0.RdData), 32'(ref_mem[6'h11]));
        @(posedge Clk);
        #1;

        // Req pulses while busy must be ignored.
        b0.Req = 1'b1; b0.WrEn = 1'b0; b0.Addr = 20'h00012;
        @(posedge Clk);
        #1 b0.Req = 1'b0;
        @(negedge Clk) b0.Req = 1'b1;
        @(posedge Clk);
        #1 b0.Req = 1'b0;
        @(negedge Clk) b0.Req = 1'b1;
        @(posedge Clk);
        #1 b0.Req = 1'b0;
        readies = 0; starts = 0; prev_busy = b0.Busy;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            if (b0.Ready) readies++;
            if (b0.Busy && !prev_busy) starts++;
            prev_busy = b0.Busy;
        end
        check("ignore_req_ready_count", readies, 1);
        check("ignore_req_no_restart", starts, 0);
        @(posedge Clk);
        #1;

        // I/O location: mapped only when the feature is built in.
        do_access(1'b1, 20'h0FFFF, 16'h00AB, "io_write");
        switches = 16'h0F0F;
        do_access(1'b0, 20'h0FFFF, 16'h0000, "io_read");

        for (int n = 0; n < 24; n++) begin
            logic        wr;
            logic [19:0] a;
            logic [15:0] d;
            wr = 1'($urandom_range(0, 1));
            a = 20'($urandom_range(0, 62));
            d = 16'($urandom);
            do_access(wr, a, d, wr ? "rand_write" : "rand_read");
        end

        // Wait-state sweep on the auxiliary instances.
        b1.Req = 1'b1; b1.WrEn = 1'b0; b1.Addr = 20'h00003;
        @(posedge Clk);
        #1 b1.Req = 1'b0;
        lat = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge Clk);
            lat++;
            if (b1.Ready) seen = 1'b1;
        end
        check("ws1_latency", lat, 3);
        @(posedge Clk);
        #1;
        check("ws1_rddata", 32'(b1.RdData), 32'h5A5A);

        b15.Req = 1'b1; b15.WrEn = 1'b0; b15.Addr = 20'h00004;
        @(posedge Clk);
        #1 b15.Req = 1'b0;
        lat = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge Clk);
            lat++;
            if (b15.Ready) seen = 1'b1;
        end
        check("ws15_latency", lat, 17);
        @(posedge Clk);
        #1;
        check("ws15_rddata", 32'(b15.RdData), 32'hA5A5);
        check("ws15_idle_busy", 32'(b15.Busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
